trace_trigger: RTL and testbench
================================

Name: trace_trigger

Overview:
- Upstream qualifier for the on-chip trace buffer: watches a raw 64-bit probe stream and drives the buffer's enable/data write port.
- Samples are forwarded while armed; a masked-compare trigger starts a post-trigger countdown, after which forwarding stops. The buffer then holds pre-trigger history plus POST samples.
- Optional change-only filtering conserves buffer depth. Control and status come from the Bscan register side.

Parameters:
- width, 64, probe and trace data width in bits.
- cntw, 16, width of the post-trigger counter and config.

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous active-high reset.
- in_valid  input  1  probe sample valid this cycle.
- in_data  input  width  probe sample.
- arm  input  1  single-cycle pulse: clear status, start capture.
- abort  input  1  single-cycle pulse: stop capture immediately.
- match_value  input  width  trigger compare value.
- match_mask  input  width  1 = bit participates in compare.
- post_count  input  cntw  samples to forward after trigger (trigger sample included).
- change_only  input  1  forward only samples differing from last forwarded.
- trace_enable  output  1  write strobe to trace buffer.
- trace_data  output  width  write data to trace buffer.
- armed  output  1  in ARMED state.
- triggered  output  1  trigger seen since last arm (sticky).
- done  output  1  capture complete (sticky).
- trig_offset  output  cntw  forwarded-sample count from arm to trigger, saturating at all-ones.

Behaviour:
- Reset (async, RST=1): state IDLE; trace_enable=0, trace_data=0, armed=0, triggered=0, done=0, trig_offset=0, remaining=0, last-forwarded reg=0, have_last=0.
- States: IDLE, ARMED, POST, DONE.
- Config inputs (match_*, post_count, change_only) are sampled on each cycle of use. They must be held stable while not IDLE. No capture copy is kept.
- Qualified sample q = in_valid & (!change_only | !have_last | in_data != last).
- hit = q & ((in_data ^ match_value) & match_mask) == 0. mask=0 means trigger on the first qualified sample.
- Forwarding: in ARMED or POST with q=1, next cycle trace_enable=1 and trace_data=in_data; last<=in_data; have_last<=1. Otherwise trace_enable=0. trace_data holds its last value. Latency is exactly 1 cycle. There is no backpressure; the buffer accepts every strobe.
- IDLE/DONE + arm: ARMED. triggered, done, trig_offset, have_last are cleared. No sample is forwarded that cycle.
- ARMED, q & !hit: forward; trig_offset += 1, saturating.
- ARMED, hit: forward; triggered<=1; remaining<=post_count-1.
  - post_count<=1: go to DONE, done<=1.
  - Else go to POST.
- POST, q: forward; remaining -= 1. When remaining==1 before the decrement, go to DONE with done<=1. Further hits in POST are ignored.
- arm while ARMED/POST: restart. Same as IDLE+arm, no forward this cycle.
- abort (any state except IDLE): go to IDLE next cycle, no forward.
  - triggered and trig_offset are kept; done stays 0.
  - abort has priority over arm and over samples.
- armed = (state==ARMED). done and triggered stay set until the next arm or reset.
- Reset mid-capture: all outputs drop to reset values immediately (asynchronous). The buffer sees trace_enable=0.

Test Plan:
- Reset, arm, mask=0, post_count=4, four valid samples 0x11..0x14 → trace_enable on 4 consecutive cycles each one cycle late, data 0x11..0x14; triggered=1, done=1, trig_offset=0.
- mask=0xFF, value=0x05, post_count=3, samples 0x01..0x07 → all 7 forwarded? No: forward 0x01..0x07 stops after 0x07. Trigger at 0x05, trig_offset=4, done after 0x07, nothing after.
- change_only=1, mask=0xFFFF_FFFF_FFFF_FFFF, value=0xAA, samples 0x1,0x1,0x2,0x2,0xAA, post_count=1 → forwarded 0x1,0x2,0xAA only; done=1, trig_offset=2.
- ARMED with in_valid gaps (valid every 3rd cycle) → trace_enable only the cycle after each valid; count and data unaffected by gaps.
- POST with 10 samples remaining, abort pulse coincident with valid sample → sample not forwarded, state IDLE, triggered=1, done=0; arm next → status cleared.
- RST asserted mid-POST between clock edges → trace_enable, status, trig_offset go to 0 without a clock edge; after release, samples are ignored until arm.

Source files
------------

// File: rtl/trace_trigger.sv
// Trace buffer qualifier: forwards probe samples while armed, applies a masked-compare
// trigger, then counts down a post-trigger window before stopping capture.
module trace_trigger #(
    parameter int width = 64,
    parameter int cntw  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    input  logic             arm,
    input  logic             abort,
    input  logic [width-1:0] match_value,
    input  logic [width-1:0] match_mask,
    input  logic [cntw-1:0]  post_count,
    input  logic             change_only,
    output logic             trace_enable,
    output logic [width-1:0] trace_data,
    output logic             armed,
    output logic             triggered,
    output logic             done,
    output logic [cntw-1:0]  trig_offset
);

    // state | meaning
    // IDLE  | not capturing; samples ignored until arm
    // ARMED | forwarding pre-trigger history, watching for a hit
    // POST  | trigger seen; forwarding the post-trigger window
    // DONE  | window complete; status held until next arm
    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    localparam logic [cntw-1:0] one = cntw'(1);

    state_t             state, state_nxt;
    logic [cntw-1:0]    remaining;
    logic [width-1:0]   last;
    logic               have_last;
    logic               q, hit;
    logic               fwd, restart, set_trig, load_post, dec_post, set_done, inc_off;

    assign q   = in_valid & (~change_only | ~have_last | (in_data != last));
    assign hit = q & (((in_data ^ match_value) & match_mask) == '0);

    assign armed = (state == ARMED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // abort outranks arm, which outranks any sample activity
    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        restart   = 1'b0;
        set_trig  = 1'b0;
        load_post = 1'b0;
        dec_post  = 1'b0;
        set_done  = 1'b0;
        inc_off   = 1'b0;
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end else if (arm) begin
            state_nxt = ARMED;
            restart   = 1'b1;
        end else begin
            case (state)
                ARMED: begin
                    if (hit) begin
                        fwd       = 1'b1;
                        set_trig  = 1'b1;
                        load_post = 1'b1;
                        if (post_count <= one) begin
                            state_nxt = DONE;
                            set_done  = 1'b1;
                        end else begin
                            state_nxt = POST;
                        end
                    end else if (q) begin
                        fwd     = 1'b1;
                        inc_off = 1'b1;
                    end
                end
                POST: begin
                    if (q) begin
                        fwd      = 1'b1;
                        dec_post = 1'b1;
                        if (remaining == one) begin
                            state_nxt = DONE;
                            set_done  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            trace_enable <= 1'b0;
            trace_data   <= '0;
            last         <= '0;
            have_last    <= 1'b0;
            remaining    <= '0;
            triggered    <= 1'b0;
            done         <= 1'b0;
            trig_offset  <= '0;
        end else begin
            trace_enable <= fwd;
            if (fwd) begin
                trace_data <= in_data;
                last       <= in_data;
                have_last  <= 1'b1;
            end
            if (restart) begin
                triggered   <= 1'b0;
                done        <= 1'b0;
                trig_offset <= '0;
                have_last   <= 1'b0;
            end
            if (set_trig)  triggered <= 1'b1;
            if (set_done)  done      <= 1'b1;
            if (load_post) remaining <= post_count - one;
            if (dec_post)  remaining <= remaining - one;
            if (inc_off && trig_offset != '1) trig_offset <= trig_offset + one;
        end
    end

endmodule

// File: tb/tb_trace_trigger.sv
// Directed bench for trace_trigger: forwarding latency, trigger/post window,
// change-only filtering, valid gaps, abort and asynchronous reset.
module tb_trace_trigger;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [63:0] in_data;
    logic        arm;
    logic        abort;
    logic [63:0] match_value;
    logic [63:0] match_mask;
    logic [15:0] post_count;
    logic        change_only;
    logic        trace_enable;
    logic [63:0] trace_data;
    logic        armed;
    logic        triggered;
    logic        done;
    logic [15:0] trig_offset;

    int pass_cnt  = 0;
    int total_cnt = 0;

    trace_trigger #(.width(64), .cntw(16)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .arm(arm), .abort(abort), .match_value(match_value), .match_mask(match_mask),
        .post_count(post_count), .change_only(change_only),
        .trace_enable(trace_enable), .trace_data(trace_data), .armed(armed),
        .triggered(triggered), .done(done), .trig_offset(trig_offset)
    );

    always #5 CLK = ~CLK;

    // one clock with the given sample; outputs observed 1 time unit after the edge
    task automatic drive(input logic v, input logic [63:0] d);
        in_valid = v;
        in_data  = d;
        arm      = 1'b0;
        abort    = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_arm();
        in_valid = 1'b0;
        arm      = 1'b1;
        abort    = 1'b0;
        @(posedge CLK);
        #1;
        arm = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; in_valid = 0; in_data = '0; arm = 0; abort = 0;
        match_value = '0; match_mask = '0; post_count = '0; change_only = 0;
        repeat (2) @(posedge CLK);
        #1;
        total_cnt++;
        if ({trace_enable, armed, triggered, done} !== 4'b0000 || trace_data !== 64'h0 || trig_offset !== 16'h0)
            $display("FAIL reset: en/armed/trig/done=%b data=%h off=%0d required all zero",
                     {trace_enable, armed, triggered, done}, trace_data, trig_offset);
        else pass_cnt++;
        RST = 1'b0;
        drive(1'b1, 64'h99);
        total_cnt++;
        if (trace_enable !== 1'b0 || armed !== 1'b0)
            $display("FAIL idle_ignore: en=%b armed=%b required 0 0", trace_enable, armed);
        else pass_cnt++;
    endtask

    task automatic test_mask_zero();
        logic [63:0] exp_d;
        match_mask = '0; match_value = '0; post_count = 16'd4; change_only = 0;
        do_arm();
        total_cnt++;
        if (armed !== 1'b1 || trace_enable !== 1'b0)
            $display("FAIL arm_state: armed=%b en=%b required 1 0", armed, trace_enable);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp_d = 64'h11 + 64'(i);
            drive(1'b1, exp_d);
            total_cnt++;
            if (trace_enable !== 1'b1 || trace_data !== exp_d)
                $display("FAIL mask0_fwd[%0d]: en=%b data=%h required 1 %h", i, trace_enable, trace_data, exp_d);
            else pass_cnt++;
        end
        total_cnt++;
        if (triggered !== 1'b1 || done !== 1'b1 || trig_offset !== 16'd0 || armed !== 1'b0)
            $display("FAIL mask0_status: trig=%b done=%b off=%0d armed=%b required 1 1 0 0",
                     triggered, done, trig_offset, armed);
        else pass_cnt++;
        drive(1'b1, 64'h15);
        total_cnt++;
        if (trace_enable !== 1'b0 || trace_data !== 64'h14)
            $display("FAIL mask0_after_done: en=%b data=%h required 0 14", trace_enable, trace_data);
        else pass_cnt++;
    endtask

    task automatic test_masked_trigger();
        logic exp_en;
        match_mask = 64'hFF; match_value = 64'h05; post_count = 16'd3; change_only = 0;
        do_arm();
        total_cnt++;
        if (triggered !== 1'b0 || done !== 1'b0 || trig_offset !== 16'd0)
            $display("FAIL rearm_clear: trig=%b done=%b off=%0d required 0 0 0", triggered, done, trig_offset);
        else pass_cnt++;
        for (int k = 1; k <= 8; k++) begin
            exp_en = (k <= 7);
            drive(1'b1, 64'(k));
            total_cnt++;
            if (trace_enable !== exp_en || (exp_en && trace_data !== 64'(k)))
                $display("FAIL masked_fwd[%0d]: en=%b data=%h required %b %h", k, trace_enable, trace_data, exp_en, 64'(k));
            else pass_cnt++;
            if (k == 5) begin
                total_cnt++;
                if (triggered !== 1'b1 || trig_offset !== 16'd4 || done !== 1'b0)
                    $display("FAIL masked_trig: trig=%b off=%0d done=%b required 1 4 0", triggered, trig_offset, done);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (done !== 1'b1 || triggered !== 1'b1)
            $display("FAIL masked_done: done=%b trig=%b required 1 1", done, triggered);
        else pass_cnt++;
    endtask

    task automatic test_change_only();
        logic [63:0] seq [5];
        logic        exp_en [5];
        seq = '{64'h1, 64'h1, 64'h2, 64'h2, 64'hAA};
        exp_en = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        match_mask = '1; match_value = 64'hAA; post_count = 16'd1; change_only = 1;
        do_arm();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i]);
            total_cnt++;
            if (trace_enable !== exp_en[i] || (exp_en[i] && trace_data !== seq[i]))
                $display("FAIL change_only[%0d]: en=%b data=%h required %b %h", i, trace_enable, trace_data, exp_en[i], seq[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (done !== 1'b1 || trig_offset !== 16'd2 || triggered !== 1'b1)
            $display("FAIL change_only_status: done=%b off=%0d trig=%b required 1 2 1", done, trig_offset, triggered);
        else pass_cnt++;
        change_only = 0;
    endtask

    task automatic test_valid_gaps();
        logic [63:0] seq [4];
        seq = '{64'h21, 64'h22, 64'h30, 64'h31};
        match_mask = 64'hFF; match_value = 64'h30; post_count = 16'd2;
        do_arm();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq[i]);
            total_cnt++;
            if (trace_enable !== 1'b1 || trace_data !== seq[i])
                $display("FAIL gap_fwd[%0d]: en=%b data=%h required 1 %h", i, trace_enable, trace_data, seq[i]);
            else pass_cnt++;
            for (int g = 0; g < 2; g++) begin
                drive(1'b0, 64'hDEAD);
                total_cnt++;
                if (trace_enable !== 1'b0 || trace_data !== seq[i])
                    $display("FAIL gap_idle[%0d.%0d]: en=%b data=%h required 0 %h", i, g, trace_enable, trace_data, seq[i]);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (done !== 1'b1 || trig_offset !== 16'd2)
            $display("FAIL gap_status: done=%b off=%0d required 1 2", done, trig_offset);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        match_mask = '0; match_value = '0; post_count = 16'd12;
        do_arm();
        drive(1'b1, 64'h40);
        drive(1'b1, 64'h41);
        in_valid = 1'b1; in_data = 64'h42; abort = 1'b1; arm = 1'b1;
        @(posedge CLK);
        #1;
        abort = 1'b0; arm = 1'b0;
        total_cnt++;
        if (trace_enable !== 1'b0 || armed !== 1'b0 || triggered !== 1'b1 || done !== 1'b0 || trace_data !== 64'h41)
            $display("FAIL abort: en=%b armed=%b trig=%b done=%b data=%h required 0 0 1 0 41",
                     trace_enable, armed, triggered, done, trace_data);
        else pass_cnt++;
        drive(1'b1, 64'h43);
        total_cnt++;
        if (trace_enable !== 1'b0 || armed !== 1'b0)
            $display("FAIL abort_idle: en=%b armed=%b required 0 0", trace_enable, armed);
        else pass_cnt++;
        do_arm();
        total_cnt++;
        if (triggered !== 1'b0 || done !== 1'b0 || armed !== 1'b1)
            $display("FAIL abort_rearm: trig=%b done=%b armed=%b required 0 0 1", triggered, done, armed);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        match_mask = 64'hFF; match_value = 64'h52; post_count = 16'd10;
        do_arm();
        drive(1'b1, 64'h51);
        drive(1'b1, 64'h52);
        drive(1'b1, 64'h53);
        total_cnt++;
        if (trace_enable !== 1'b1 || triggered !== 1'b1 || trig_offset !== 16'd1)
            $display("FAIL pre_reset: en=%b trig=%b off=%0d required 1 1 1", trace_enable, triggered, trig_offset);
        else pass_cnt++;
        #2 RST = 1'b1;
        #1;
        total_cnt++;
        if ({trace_enable, armed, triggered, done} !== 4'b0000 || trace_data !== 64'h0 || trig_offset !== 16'h0)
            $display("FAIL async_reset: en/armed/trig/done=%b data=%h off=%0d required all zero",
                     {trace_enable, armed, triggered, done}, trace_data, trig_offset);
        else pass_cnt++;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h52);
            total_cnt++;
            if (trace_enable !== 1'b0 || armed !== 1'b0 || triggered !== 1'b0)
                $display("FAIL post_reset_idle[%0d]: en=%b armed=%b trig=%b required 0 0 0", i, trace_enable, armed, triggered);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_mask_zero();
        test_masked_trigger();
        test_change_only();
        test_valid_gaps();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
